// File: rtl/memory_program_loader.sv
// Byte-stream program loader: assembles incoming bytes into little-endian
// DATA_WIDTH words and writes them to consecutive memory word addresses while
// holding the CPU off the memory port.
module memory_program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  slow_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  allow_write_on_memory,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            checksum
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [7:0]            r_checksum;

  logic                  w_accept;
  logic                  w_last_byte;
  logic [DATA_WIDTH-1:0] w_word_merged;

  // An abort in COLLECT wins over a coincident byte: the byte is not counted.
  assign w_accept    = (r_state == S_COLLECT) & in_valid & ~abort;
  assign w_last_byte = (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  // Word with the incoming byte dropped into the current lane (lane 0 = LSB).
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign w_word_merged[gi*8 +: 8] =
        (r_byte_idx == IDX_W'(gi)) ? in_data : r_word[gi*8 +: 8];
    end
  endgenerate

  assign in_ready              = (r_state == S_COLLECT);
  assign allow_write_on_memory = (r_state == S_WRITE);
  assign busy                  = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign cpu_hold              = busy;
  assign done                  = (r_state == S_DONE);
  assign mem_address           = r_mem_address;
  assign mem_data              = r_mem_data;
  assign checksum              = r_checksum;

  // State register.
  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = (word_count != '0) ? S_COLLECT : S_DONE;
      end
      S_COLLECT: begin
        if (abort)                        w_state_next = S_IDLE;
        else if (w_accept && w_last_byte) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (abort)                                   w_state_next = S_IDLE;
        else if (r_remaining == ADDR_WIDTH'(1))      w_state_next = S_DONE;
        else                                         w_state_next = S_COLLECT;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: address/count tracking, byte assembly, checksum, write port.
  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_byte_idx    <= '0;
      r_word        <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_checksum    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_address;
            r_remaining <= word_count;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_checksum  <= '0;
          end
        end
        S_COLLECT: begin
          if (abort) begin
            // Partial word is dropped; checksum keeps what was accepted.
            r_byte_idx <= '0;
            r_word     <= '0;
          end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
            if (w_last_byte) begin
              // Latch the write port so it is stable through WRITE and after.
              r_mem_address <= r_addr;
              r_mem_data    <= w_word_merged;
              r_word        <= '0;
              r_byte_idx    <= '0;
            end else begin
              r_word     <= w_word_merged;
              r_byte_idx <= r_byte_idx + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          r_remaining <= r_remaining - ADDR_WIDTH'(1);
          if (r_remaining != ADDR_WIDTH'(1)) r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_program_loader.sv
// Scoreboard bench for memory_program_loader: the driver pushes expected
// writes derived from the byte stream; a negedge monitor checks every strobe.
module tb_memory_program_loader;

  logic        slow_clock = 1'b0;
  logic        reset      = 1'b0;
  logic        start      = 1'b0;
  logic        abort      = 1'b0;
  logic [13:0] base_address = '0;
  logic [13:0] word_count   = '0;
  logic [7:0]  in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] mem_address;
  logic [31:0] mem_data;
  logic        allow_write_on_memory;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  memory_program_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) dut (
    .slow_clock(slow_clock), .reset(reset), .start(start), .abort(abort),
    .base_address(base_address), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_data(mem_data),
    .allow_write_on_memory(allow_write_on_memory),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t exp_q[$];
  int  exp_done_pending = 0;
  bit  exp_done_lag     = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  mon_cyc  = 0;
  int  last_write_cyc = -10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: compares every write strobe and done pulse against the scoreboard.
  always @(negedge slow_clock) begin
    mon_cyc++;
    if (reset) begin
      if (cpu_hold !== busy) check("cpu_hold_eq_busy", cpu_hold, busy);
      if (allow_write_on_memory) begin
        wr_t e;
        last_write_cyc = mon_cyc;
        check("in_ready_low_in_write", in_ready, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", mem_address, 14'h0);
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none queued", mem_address, mem_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", mem_address, e.a);
          check("write_data", mem_data, e.d);
        end
      end
      if (done) begin
        if (exp_done_pending == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          exp_done_pending--;
          if (exp_done_lag) check("done_one_cycle_after_write", mon_cyc - last_write_cyc, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap;
    int t;
    gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("in_ready_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) begin
        ok = 1;
        break;
      end
    end
    check("done_seen", ok, 1'b1);
  endtask

  // One load: expected writes come from the byte list by simple packing.
  // abort_at < 0: complete load; otherwise abort after that many bytes.
  task automatic do_load(input logic [13:0] base, input logic [13:0] cnt,
                         input byte_q_t bq_in, input int gapmax,
                         input int abort_at, input bit abort_with_start);
    byte_q_t bq;
    int      nbytes;
    int      nsent;
    int      nwr;
    logic [7:0] sum;
    bq = bq_in;
    nbytes = int'(cnt) * 4;
    while (bq.size() < nbytes) bq.push_back(8'($urandom));
    nsent = (abort_at < 0) ? nbytes : abort_at;
    nwr   = nsent / 4;
    sum = 8'h00;
    for (int i = 0; i < nsent; i++) sum = sum + bq[i];
    for (int w = 0; w < nwr; w++) begin
      wr_t e;
      e.a = base + 14'(w);
      e.d = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
      exp_q.push_back(e);
    end
    if (abort_at < 0) begin
      exp_done_pending++;
      exp_done_lag = (cnt != 0);
    end
    start        = 1'b1;
    abort        = abort_with_start;
    base_address = base;
    word_count   = cnt;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("busy_after_start", busy, cnt != 0);
    if (cnt == 0) check("zero_count_done", done, 1'b1);
    for (int i = 0; i < nsent; i++) send_byte(bq[i], gapmax);
    if (abort_at >= 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle_busy", busy, 1'b0);
      check("abort_no_done", done, 1'b0);
      repeat (5) tick();
      check("abort_checksum", checksum, sum);
    end else if (cnt != 0) begin
      wait_done();
      check("checksum", checksum, sum);
      tick();
    end else begin
      check("zero_count_checksum", checksum, 8'h00);
      tick();
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_pending_zero", exp_done_pending, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_write"}, allow_write_on_memory, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_mem_address"}, mem_address, 14'h0);
    check({tag, "_mem_data"}, mem_data, 32'h0);
    check({tag, "_checksum"}, checksum, 8'h00);
  endtask

  initial begin
    byte_q_t none;
    byte_q_t fixed;
    none = {};
    fixed = {8'h78, 8'h56, 8'h34, 8'h12};

    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single word, back-to-back bytes.
    do_load(14'h0010, 14'd1, fixed, 0, -1, 1'b0);
    // Multi-word with random gaps.
    do_load(14'h0100, 14'd3, none, 3, -1, 1'b0);
    // Address wrap; abort raised with start must be ignored.
    do_load(14'h3FFF, 14'd2, none, 1, -1, 1'b1);
    // Zero count.
    do_load(14'h0200, 14'd0, none, 0, -1, 1'b0);
    // Abort after 2 bytes of the first word.
    do_load(14'h0300, 14'd2, none, 1, 2, 1'b0);
    // Abort during the second WRITE.
    do_load(14'h0400, 14'd2, none, 0, 8, 1'b0);

    // Reset mid-load: word 0 written, reset during word 1.
    begin
      wr_t e;
      byte_q_t bq;
      bq = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      e.a = 14'h0500;
      e.d = 32'hD4C3B2A1;
      exp_q.push_back(e);
      start = 1'b1; base_address = 14'h0500; word_count = 14'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(bq[i], 1);
      #2 reset = 1'b0;
      #1 check_all_zero("mid_reset");
      tick();
      reset = 1'b1;
      tick();
      check("mid_reset_drained", exp_q.size(), 0);
    end
    do_load(14'h0600, 14'd1, none, 1, -1, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 5; r++)
      do_load(14'($urandom), 14'($urandom_range(1, 4)), none, 3, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_program_loader.md
Name: memory_program_loader

Overview:
- Writer-side counterpart of the memory unit's read path: receives a byte stream (e.g. from a serial receiver) and writes it into main memory as DATA_WIDTH words.
- Holds the CPU while loading, so new programs can be placed in memory without rebuilding the memory initialisation image.
- Drives the same write-enable/address/data triple that the memory unit consumes from the CPU.
- A top-level mux selects between loader and CPU using cpu_hold.

Parameters:
DATA_WIDTH, 32, memory word width; must be a multiple of 8; BYTES_PER_WORD = DATA_WIDTH/8 (derived).
ADDR_WIDTH, 14, memory word-address width.

Ports:
slow_clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  begin a load; sampled only in IDLE.
abort  input  1  cancel an in-progress load; synchronous.
base_address  input  ADDR_WIDTH  first word address; sampled with start.
word_count  input  ADDR_WIDTH  number of words to load; sampled with start.
in_data  input  8  incoming byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle.
mem_address  output  ADDR_WIDTH  write address.
mem_data  output  DATA_WIDTH  assembled write word.
allow_write_on_memory  output  1  one-cycle write strobe.
cpu_hold  output  1  CPU must stall; equals busy.
busy  output  1  load in progress.
done  output  1  one-cycle pulse on successful completion.
checksum  output  8  modulo-256 sum of all bytes accepted since the last start.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0: in_ready, allow_write_on_memory, busy, cpu_hold, done, mem_address, mem_data, checksum.
  - Internal byte index and remaining count are cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - busy=0, in_ready=0.
  - start=1 and word_count!=0 -> COLLECT. Same edge: addr<=base_address, remaining<=word_count, byte_idx<=0, checksum<=0, word<=0.
  - start=1 and word_count==0 -> DONE (done pulses next cycle, no writes); checksum<=0.
- COLLECT:
  - busy=1, in_ready=1.
  - A byte transfer occurs when in_valid & in_ready.
  - On a transfer: the byte goes into lane byte_idx (lane 0 = bits 7:0, little-endian), checksum<=checksum+in_data (wraps mod 256), byte_idx increments.
  - Transfer with byte_idx==BYTES_PER_WORD-1 -> WRITE, byte_idx<=0.
  - No in_valid -> stay; no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, allow_write_on_memory=1, mem_address=addr, mem_data=assembled word.
  - mem_address and mem_data stay stable for the whole cycle.
  - Next edge: remaining<=remaining-1.
  - If remaining==1 -> DONE.
  - Otherwise addr<=addr+1 and -> COLLECT. The address wraps mod 2^ADDR_WIDTH: 0x3FFF+1 = 0x0000 for the default width.
- DONE (one cycle): done=1, busy=0, then -> IDLE.
- Throughput: max 1 word per BYTES_PER_WORD+1 cycles; a byte offered during WRITE is held by the source, since in_ready=0.
- abort=1 in COLLECT:
  - Next state is IDLE; no done.
  - The partial word is discarded and never written.
  - checksum holds its value.
- abort=1 in WRITE: the write strobe in that cycle is still issued (it is already asserted); next state is IDLE, no done.
- abort in IDLE/DONE: ignored; DONE still pulses and returns to IDLE.
- start while not IDLE: ignored.
- start and abort together in IDLE: start wins.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. The current word is lost and the write strobe drops asynchronously.
- Outside WRITE, mem_address and mem_data hold their last driven values. Consumers must qualify them with allow_write_on_memory.

Test Plan:
- Single word:
  - Stimulus: start, base=0x0010, count=1, bytes 0x78,0x56,0x34,0x12 back-to-back.
  - Required: one strobe with addr 0x0010, data 0x12345678; done pulses 1 cycle after the write; checksum=0x14.
  - Required: busy/cpu_hold high from the cycle after start until DONE.
- Multi-word with gaps:
  - Stimulus: count=3, base=0x0100; in_valid toggles randomly.
  - Required: strobes at 0x0100, 0x0101, 0x0102 in order, each exactly 1 cycle; no byte lost or duplicated; in_ready=0 during each WRITE.
- Wrap-around:
  - Stimulus: base=0x3FFF, count=2.
  - Required: writes to 0x3FFF then 0x0000; done pulses once.
- Zero count:
  - Stimulus: start with count=0.
  - Required: no strobe; done pulses one cycle later; checksum=0.
- Abort:
  - Stimulus: count=2, abort after 2 bytes of word 1.
  - Required: no strobe; no done; IDLE next cycle.
  - Stimulus: abort during the second WRITE.
  - Required: that write is issued, then IDLE with no done.
- Reset mid-load:
  - Stimulus: drop reset during COLLECT, then release it.
  - Required: all outputs 0 immediately.
  - Stimulus: a new start after release.
  - Required: the load succeeds; checksum counts only the new bytes.
